jtag_cmd_sink: RTL
==================

// Module: jtag_cmd_sink
// PURPOSE
//  Downstream consumer of a JTAG user-chain update register. Accepts each 9-bit word
//  strobed out on JUPDATE and buffers it in a small FIFO. Drains words as decoded
//  commands over a valid/ready port and mirrors write commands into a 16x4 register
//  file. Returns a 9-bit status/readback word for the chain's capture phase.
//  Register 0 drives LEDS_columns.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of two, 2..8
// PORTS
//  JTCK          in   1  sole clock, all state on posedge
//  JRSTN         in   1  asynchronous active-low reset
//  in_valid      in   1  1-cycle push strobe (chain JUPDATE qualified by chain select)
//  in_word       in   9  {wr[8], addr[7:4], data[3:0]}
//  cmd_valid     out  1  FIFO head valid
//  cmd_ready     in   1  consumer accepts head when cmd_valid & cmd_ready
//  cmd_write     out  1  head wr bit
//  cmd_addr      out  4  head addr
//  cmd_data      out  4  head data
//  rd_data       out  9  {overflow, level[3:0], rd_latch[3:0]}; chain capture source
//  level         out  4  FIFO occupancy, 0..DEPTH
//  overflow      out  1  sticky; set when a push is dropped
//  ovf_clr       in   1  synchronous clear of overflow (and err_count)
//  LEDS_columns  out  4  regfile[0]
//  err_count     out  4  dropped-push counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (JRSTN=0, async): FIFO empty, rd/wr pointers 0, level=0, cmd_valid=0,
//    cmd_* fields=0, overflow=0, rd_latch=0, all regfile entries=0, LEDS_columns=0,
//    err_count=0. Reset mid-transfer discards all buffered words.
//  - Push: in_valid at edge N stores the word; it is visible at edge N+1.
//    No same-cycle bypass: an empty FIFO raises cmd_valid one cycle after in_valid.
//  - Pop: cmd_valid & cmd_ready at an edge retires the head. The next entry appears
//    on cmd_* after that edge. cmd_* hold stable while cmd_valid=1 & cmd_ready=0.
//  - Head fields are combinational from the FIFO storage array, indexed by the
//    read pointer. cmd_write/addr/data are don't-care when cmd_valid=0 but are
//    driven 0 after reset.
//  - Full (level==DEPTH) with in_valid and no pop: word dropped, overflow<=1,
//    FIFO contents unchanged.
//  - Full with in_valid and pop in the same cycle: push accepted, level unchanged.
//  - Empty with pop: cmd_ready is ignored when cmd_valid=0.
//  - Simultaneous push and pop (not full): level unchanged, both pointers advance.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Level is tracked
//    separately: +1 on push only, -1 on pop only.
//  - Accepted write (cmd_write=1): regfile[cmd_addr] <= cmd_data at the pop edge.
//    Address 0 changes LEDS_columns on the edge after acceptance.
//  - Accepted read (cmd_write=0): rd_latch <= regfile[cmd_addr] at the pop edge.
//    The regfile reads the value before any same-edge update.
//  - ovf_clr together with a dropping push: the set wins, overflow=1.
//  - rd_data is combinational from registered state. level is zero-extended to 4 bits.
// CONFIGURATION
//  - JTAG_CMD_ERRCNT_EN defined: err_count is a 4-bit saturating counter.
//    +1 per dropped push, holds at 15, cleared by ovf_clr (set-side increment wins).
//  - Not defined: err_count is tied to 4'd0 and no counter logic is generated.
// TESTING
//  - Reset then idle 5 cycles -> cmd_valid=0, level=0, rd_data=9'h000, LEDS_columns=0.
//  - Push 9'h10A (wr, addr0, data A), cmd_ready=1 -> cmd_valid high 1 cycle after
//    push; LEDS_columns=4'hA 1 cycle after accept; level back to 0.
//  - cmd_ready=0, push 5 words with DEPTH=4 -> level=4, overflow=1, words 1..4 pop
//    in order; with ERRCNT_EN err_count=1. Then ovf_clr -> overflow=0, err_count=0.
//  - Fill to 4 entries, then in_valid and cmd_ready in the same cycle -> no drop,
//    level=4, overflow stays 0.
//  - Write 9'h135 (reg3=5), then read 9'h030 -> rd_data[3:0]=4'h5 after read
//    accept; rd_data[7:4] shows live level.
//  - Assert JRSTN low while 3 words are queued and cmd_valid=1 -> all outputs 0
//    immediately (async). After release the first push takes 1 cycle to show cmd_valid.

Source files
------------

// File: rtl/jtag_cmd_sink.sv
// rtl/jtag_cmd_sink.sv - JTAG user-chain update sink: word FIFO, command port, 16x4 regfile, capture readback
// Optional feature macro: JTAG_CMD_ERRCNT_EN (saturating dropped-push counter on err_count)
module jtag_cmd_sink #(
  parameter int DEPTH = 4
) (
  input  logic       JTCK,
  input  logic       JRSTN,
  input  logic       in_valid,
  input  logic [8:0] in_word,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_write,
  output logic [3:0] cmd_addr,
  output logic [3:0] cmd_data,
  output logic [8:0] rd_data,
  output logic [3:0] level,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic [3:0] LEDS_columns,
  output logic [3:0] err_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [8:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    level_q, level_d;
  logic          overflow_q;
  logic [3:0]    rd_latch_q;
  logic [3:0]    regfile_q [16];

  logic [8:0] head;
  logic       full;
  logic       pop;
  logic       push_ok;
  logic       drop;

  // Head of queue and handshake qualifiers; a full FIFO still accepts when it also pops.
  always_comb begin
    head    = mem_q[rd_ptr_q];
    full    = (level_q == 4'(DEPTH));
    pop     = (level_q != 4'd0) && cmd_ready;
    push_ok = in_valid && (!full || pop);
    drop    = in_valid && full && !pop;
  end

  // Pointer and occupancy next-state; level only moves when exactly one side is active.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      level_d = level_q + 4'd1;
    else if (pop && !push_ok) level_d = level_q - 4'd1;
  end

  // FIFO storage, pointers, level and sticky overflow (set beats clear).
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 9'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= in_word;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (drop)         overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
    end
  end

  // Command execution at the pop edge; reads see the regfile before any same-edge write.
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      for (int i = 0; i < 16; i++) regfile_q[i] <= 4'd0;
      rd_latch_q <= 4'd0;
    end else if (pop) begin
      if (head[8]) regfile_q[head[7:4]] <= head[3:0];
      else         rd_latch_q <= regfile_q[head[7:4]];
    end
  end

`ifdef JTAG_CMD_ERRCNT_EN
  logic [3:0] err_q;

  // Saturating dropped-push counter; an increment beats a clear in the same cycle.
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      err_q <= 4'd0;
    end else if (drop) begin
      if (err_q != 4'hF) err_q <= err_q + 4'd1;
    end else if (ovf_clr) begin
      err_q <= 4'd0;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 4'd0;
`endif

  assign cmd_valid    = (level_q != 4'd0);
  assign cmd_write    = head[8];
  assign cmd_addr     = head[7:4];
  assign cmd_data     = head[3:0];
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign rd_data      = {overflow_q, level_q, rd_latch_q};
  assign LEDS_columns = regfile_q[0];

endmodule
